// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl -- PLL start-up and lock supervision.
//
// Pulses the PLL reset, waits (with timeout) for the PLL to report lock,
// requires the lock to stay up for a number of consecutive cycles, then
// releases the downstream system reset. A lock loss in RUN restarts the
// whole sequence. Lock losses and lock timeouts are counted (saturating).
//
// Parameters
//   PLL_RST_CYCLES  cycles pll_rst is held per PLL reset pulse (>=1)
//   TIMEOUT_CYCLES  cycles allowed in WAIT_LOCK before re-resetting (>=2)
//   STABLE_CYCLES   consecutive locked cycles required before RUN (>=1)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   locked_in      PLL lock flag, asynchronous to clk
//   pll_rst        reset request to the PLL (registered)
//   sys_rst        active-high reset for downstream logic (registered)
//   ready          high only in RUN (registered)
//   state          PLL_RESET=0, WAIT_LOCK=1, STABLE_WAIT=2, RUN=3
//   lock_lost_cnt  lock losses seen in RUN, saturates at 255
//   timeout_cnt    WAIT_LOCK timeouts, saturates at 255
//
// Build option
//   PLL_LOCK_DEGLITCH_EN  defined: a lock loss in RUN needs 4 consecutive
//                         cycles of locked_sync=0; undefined: one cycle.
//
// state       | meaning
// PLL_RESET   | pll_rst asserted for PLL_RST_CYCLES cycles
// WAIT_LOCK   | PLL released, waiting for locked_sync (with timeout)
// STABLE_WAIT | lock seen, counting consecutive locked cycles
// RUN         | system reset released, watching for lock loss

module pll_lock_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_lost_cnt,
  output logic [7:0] timeout_cnt
);

  typedef enum logic [1:0] {
    PLL_RESET   = 2'd0,
    WAIT_LOCK   = 2'd1,
    STABLE_WAIT = 2'd2,
    RUN         = 2'd3
  } state_e;

  localparam int MAX_AB = (PLL_RST_CYCLES > TIMEOUT_CYCLES) ? PLL_RST_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lost_q, lost_d;
  logic [7:0]    to_q, to_d;
  logic          sync1_q, locked_sync_q;
  logic          pll_rst_q, sys_rst_q, ready_q;
  logic          lock_loss;

  // Two-flop synchronizer; only locked_sync_q is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      locked_sync_q <= 1'b0;
    end else begin
      sync1_q       <= locked_in;
      locked_sync_q <= sync1_q;
    end
  end

`ifdef PLL_LOCK_DEGLITCH_EN
  // Counts consecutive unlocked cycles in RUN; the fourth one is a loss.
  logic [1:0] dg_q, dg_d;

  always_comb begin
    dg_d      = 2'd0;
    lock_loss = 1'b0;
    if (state_q == RUN && !locked_sync_q) begin
      if (dg_q == 2'd3) lock_loss = 1'b1;
      else              dg_d      = dg_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dg_q <= 2'd0;
    else     dg_q <= dg_d;
  end
`else
  always_comb begin
    lock_loss = (state_q == RUN) && !locked_sync_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    lost_d  = lost_q;
    to_d    = to_q;

    case (state_q)
      PLL_RESET: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_sync_q) begin
          state_d = STABLE_WAIT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RESET;
          if (to_q != 8'hFF) to_d = to_q + 8'd1;
        end
      end
      STABLE_WAIT: begin
        if (!locked_sync_q)            state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        // The timer has no meaning in RUN; hold it instead of free-running.
        cnt_d = cnt_q;
        if (lock_loss) begin
          state_d = PLL_RESET;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      default: state_d = PLL_RESET;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      lost_q    <= 8'd0;
      to_q      <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
      to_q      <= to_d;
      // Decoded from the next state so the flops line up with state_q.
      pll_rst_q <= (state_d == PLL_RESET);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign lock_lost_cnt = lost_q;
  assign timeout_cnt   = to_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with PLL_RST_CYCLES=4, TIMEOUT_CYCLES=32,
// STABLE_CYCLES=8. Inputs change and outputs are sampled 1 ns after rising
// edges; "rN" in comments is the N-th rising edge after rst is released.
module tb_pll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_in = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [1:0] state;
  logic [7:0] lock_lost_cnt, timeout_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_lock_ctrl #(
    .PLL_RST_CYCLES(4),
    .TIMEOUT_CYCLES(32),
    .STABLE_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .locked_in    (locked_in),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .state        (state),
    .lock_lost_cnt(lock_lost_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] want, input int budget);
    int n;
    n = 0;
    while (state !== want && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(state), 32'(want));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset held 3 cycles, no lock ever: pulse, timeout, pulse
    rst = 1'b1;
    locked_in = 1'b0;
    tick(3);
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_sys_rst", 32'(sys_rst), 1);
    chk("rst_ready",   32'(ready), 0);
    chk("rst_state",   32'(state), 0);
    chk("rst_lost",    32'(lock_lost_cnt), 0);
    chk("rst_to",      32'(timeout_cnt), 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk("pll_rst_hold", 32'(pll_rst), 1);
    end
    tick(1);                                   // r4
    chk("wl_enter_state", 32'(state), 1);
    chk("wl_enter_pll_rst", 32'(pll_rst), 0);
    for (int i = 5; i <= 35; i++) begin
      tick(1);
      chk("wl_pll_rst_low", 32'(pll_rst), 0);
      chk("wl_sys_rst", 32'(sys_rst), 1);
    end
    tick(1);                                   // r36: timeout
    chk("to_state",   32'(state), 0);
    chk("to_pll_rst", 32'(pll_rst), 1);
    chk("to_cnt",     32'(timeout_cnt), 1);
    chk("to_sys_rst", 32'(sys_rst), 1);
    tick(3);                                   // r39
    chk("to_pulse_end", 32'(pll_rst), 1);
    tick(1);                                   // r40
    chk("to_pulse_done", 32'(pll_rst), 0);
    chk("to_back_wl", 32'(state), 1);
    chk("to_sys_rst2", 32'(sys_rst), 1);

    // ---- lock arriving exactly on the timeout edge wins
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(33);
    locked_in = 1'b1;
    tick(2);                                   // r35
    chk("coin_pre_state", 32'(state), 1);
    tick(1);                                   // r36
    chk("coin_state", 32'(state), 2);
    chk("coin_to_cnt", 32'(timeout_cnt), 0);

    // ---- normal lock-up
    rst = 1'b1;
    locked_in = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(10);
    locked_in = 1'b1;
    tick(2);                                   // r12: sync latency
    chk("sync_lat_state", 32'(state), 1);
    tick(1);                                   // r13
    chk("sw_enter", 32'(state), 2);
    tick(7);                                   // r20
    chk("sw_last_state", 32'(state), 2);
    chk("sw_last_sys_rst", 32'(sys_rst), 1);
    chk("sw_last_ready", 32'(ready), 0);
    tick(1);                                   // r21
    chk("run_state", 32'(state), 3);
    chk("run_ready", 32'(ready), 1);
    chk("run_sys_rst", 32'(sys_rst), 0);
    chk("run_pll_rst", 32'(pll_rst), 0);

    // ---- one-cycle lock drop in RUN
    locked_in = 1'b0;
    tick(1);                                   // r22
    locked_in = 1'b1;
    tick(1);                                   // r23
    chk("drop1_pre", 32'(state), 3);
    tick(1);                                   // r24
`ifdef PLL_LOCK_DEGLITCH_EN
    chk("drop1_state", 32'(state), 3);
    chk("drop1_sys_rst", 32'(sys_rst), 0);
    chk("drop1_lost", 32'(lock_lost_cnt), 0);
    tick(4);
    chk("drop1_still_run", 32'(state), 3);
    chk("drop1_ready", 32'(ready), 1);
`else
    chk("drop1_state", 32'(state), 0);
    chk("drop1_sys_rst", 32'(sys_rst), 1);
    chk("drop1_pll_rst", 32'(pll_rst), 1);
    chk("drop1_ready", 32'(ready), 0);
    chk("drop1_lost", 32'(lock_lost_cnt), 1);
    tick(3);                                   // r27
    chk("drop1_pulse_end", 32'(pll_rst), 1);
    tick(1);                                   // r28
    chk("drop1_pulse_done", 32'(pll_rst), 0);
    chk("drop1_wl", 32'(state), 1);
    wait_state("drop1_relock", 2'd3, 40);
`endif

    // ---- four-cycle lock drop in RUN: a loss in both builds
    locked_in = 1'b0;
    tick(2);                                   // s2
    chk("drop4_pre", 32'(state), 3);
    tick(2);                                   // s4
    locked_in = 1'b1;
    tick(1);                                   // s5
`ifdef PLL_LOCK_DEGLITCH_EN
    chk("drop4_s5", 32'(state), 3);
`else
    chk("drop4_s5", 32'(state), 0);
`endif
    tick(1);                                   // s6
    chk("drop4_state", 32'(state), 0);
    chk("drop4_sys_rst", 32'(sys_rst), 1);
`ifdef PLL_LOCK_DEGLITCH_EN
    chk("drop4_lost", 32'(lock_lost_cnt), 1);
`else
    chk("drop4_lost", 32'(lock_lost_cnt), 2);
`endif
    wait_state("drop4_relock", 2'd3, 60);

    // ---- lock glitch during STABLE_WAIT restarts the stability count
    rst = 1'b1;
    locked_in = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);                                   // r5
    chk("swg_enter", 32'(state), 2);
    tick(3);                                   // r8
    locked_in = 1'b0;
    tick(1);                                   // r9
    locked_in = 1'b1;
    tick(1);                                   // r10
    chk("swg_pre", 32'(state), 2);
    tick(1);                                   // r11
    chk("swg_back_wl", 32'(state), 1);
    chk("swg_sys_rst", 32'(sys_rst), 1);
    chk("swg_lost", 32'(lock_lost_cnt), 0);
    chk("swg_to", 32'(timeout_cnt), 0);
    tick(1);                                   // r12
    chk("swg_reenter", 32'(state), 2);
    tick(1);                                   // r13
    chk("swg_no_early_run", 32'(state), 2);
    tick(6);                                   // r19
    chk("swg_last", 32'(state), 2);
    tick(1);                                   // r20
    chk("swg_run", 32'(state), 3);

    // ---- 300 lock losses: counter saturates at 255
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wait_state("sat_run0", 2'd3, 60);
    for (int i = 0; i < 300; i++) begin
      locked_in = 1'b0;
      tick(4);
      locked_in = 1'b1;
      tick(2);
      if (i == 253) chk("sat_254", 32'(lock_lost_cnt), 254);
      if (i == 254) chk("sat_255", 32'(lock_lost_cnt), 255);
      wait_state("sat_relock", 2'd3, 60);
    end
    chk("sat_final", 32'(lock_lost_cnt), 255);
    chk("sat_to", 32'(timeout_cnt), 0);

    // ---- one-cycle reset from RUN
    rst = 1'b1;
    tick(1);
    chk("mrst_sys_rst", 32'(sys_rst), 1);
    chk("mrst_pll_rst", 32'(pll_rst), 1);
    chk("mrst_ready", 32'(ready), 0);
    chk("mrst_state", 32'(state), 0);
    chk("mrst_lost", 32'(lock_lost_cnt), 0);
    chk("mrst_to", 32'(timeout_cnt), 0);
    rst = 1'b0;
    tick(3);
    chk("mrst_pulse_end", 32'(pll_rst), 1);
    tick(1);
    chk("mrst_pulse_done", 32'(pll_rst), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
